// File: rtl/cgra_pkg.sv
// Shared state encoding, width defaults and drain depth for the CGRA execution controller.
package cgra_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } exec_state_e;

  localparam int INST_AWIDTH_DEF = 10;
  localparam int ITER_WIDTH_DEF  = 16;

  // 2 instruction regs + data memory read reg + ALU reg + write-back.
  localparam int PE_PIPE_DEPTH    = 5;
  localparam int DRAIN_MARGIN     = 3;
  localparam int DRAIN_CYCLES_DEF = PE_PIPE_DEPTH + DRAIN_MARGIN;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cgra_addr_gen.sv
// Program-window address counter: walks start..end, wraps per iteration, flags the final issue.
module cgra_addr_gen
  import cgra_pkg::*;
#(
  parameter int INST_AWIDTH = INST_AWIDTH_DEF,
  parameter int ITER_WIDTH  = ITER_WIDTH_DEF
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   load,
  input  logic                   step,
  input  logic [INST_AWIDTH-1:0] start_addr,
  input  logic [INST_AWIDTH-1:0] end_addr,
  input  logic [ITER_WIDTH-1:0]  iter_num,
  output logic [INST_AWIDTH-1:0] addr,
  output logic                   last
);

  logic [INST_AWIDTH-1:0] base_addr;
  logic [INST_AWIDTH-1:0] top_addr;
  logic [ITER_WIDTH-1:0]  iter_left;

  // NOTE: registers use non-blocking assignments so every reader sees the pre-edge value.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      base_addr <= '0;
      top_addr  <= '0;
      addr      <= '0;
      iter_left <= '0;
    end else if (load) begin
      base_addr <= start_addr;
      top_addr  <= end_addr;
      addr      <= start_addr;
      iter_left <= iter_num;
    end else if (step) begin
      if (addr < top_addr) begin
        addr <= addr + 1'b1;
      end else if (iter_left > ITER_WIDTH'(1)) begin
        addr      <= base_addr;
        iter_left <= iter_left - ITER_WIDTH'(1);
      end
    end
  end

  // Final address of the final pass; stepping here leaves the counter parked.
  assign last = (addr == top_addr) && (iter_left == ITER_WIDTH'(1));

endmodule

// File: rtl/cgra_exec_ctrl.sv
// Execution sequencer for one CGRA PE array: issue window, drain PE pipeline, pulse Done.
// Optional cycle counters (Run_Cycles, Stall_Cycles) when CGRA_EXEC_PERF_CNT_EN is defined.
module cgra_exec_ctrl
  import cgra_pkg::*;
#(
  parameter int INST_AWIDTH  = INST_AWIDTH_DEF,
  parameter int ITER_WIDTH   = ITER_WIDTH_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic                   Abort,
  input  logic                   Stall,
  input  logic [INST_AWIDTH-1:0] Start_Addr,
  input  logic [INST_AWIDTH-1:0] End_Addr,
  input  logic [ITER_WIDTH-1:0]  Iter_Num,
  output logic [INST_AWIDTH-1:0] Inst_Addr,
  output logic                   CGRA_Ena,
  output logic                   Busy,
  output logic                   Done,
`ifdef CGRA_EXEC_PERF_CNT_EN
  output logic                   Err,
  output logic [31:0]            Run_Cycles,
  output logic [31:0]            Stall_Cycles
`else
  output logic                   Err
`endif
);

  localparam int DRAIN_W = cnt_width(DRAIN_CYCLES);

  exec_state_e        state;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               cfg_err;
  logic               start_ok;
  logic               gen_load;
  logic               gen_step;
  logic               gen_last;

  assign cfg_err  = End_Addr < Start_Addr;
  assign start_ok = (state == IDLE) && Start && !cfg_err;
  assign gen_load = start_ok && (Iter_Num != '0);
  assign gen_step = (state == RUN) && !Stall && !Abort;

  cgra_addr_gen #(
    .INST_AWIDTH (INST_AWIDTH),
    .ITER_WIDTH  (ITER_WIDTH)
  ) u_addr_gen (
    .Clk        (Clk),
    .Reset      (Reset),
    .load       (gen_load),
    .step       (gen_step),
    .start_addr (Start_Addr),
    .end_addr   (End_Addr),
    .iter_num   (Iter_Num),
    .addr       (Inst_Addr),
    .last       (gen_last)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      drain_cnt <= '0;
      CGRA_Ena  <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Err       <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low every cycle; a branch below raises them for one clock.
      Done <= 1'b0;
      Err  <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            if (cfg_err) begin
              Err <= 1'b1;
            end else if (Iter_Num == '0) begin
              // Zero passes: one busy cycle through an empty drain, then Done.
              state     <= DRAIN;
              drain_cnt <= '0;
              Busy      <= 1'b1;
            end else begin
              state    <= RUN;
              CGRA_Ena <= 1'b1;
              Busy     <= 1'b1;
            end
          end
        end
        RUN: begin
          if (Abort) begin
            state    <= IDLE;
            CGRA_Ena <= 1'b0;
            Busy     <= 1'b0;
          end else if (Stall) begin
            CGRA_Ena <= 1'b0;
          end else if (gen_last) begin
            state     <= DRAIN;
            CGRA_Ena  <= 1'b0;
            drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
          end else begin
            CGRA_Ena <= 1'b1;
          end
        end
        DRAIN: begin
          if (Abort) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end else if (drain_cnt == '0) begin
            state <= DONE;
            Done  <= 1'b1;
            Busy  <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          CGRA_Ena <= 1'b0;
          Busy     <= 1'b0;
        end
      endcase
    end
  end

`ifdef CGRA_EXEC_PERF_CNT_EN
  // Counters hold after Done so the host can read them until the next accepted Start.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Run_Cycles   <= '0;
      Stall_Cycles <= '0;
    end else if (start_ok) begin
      Run_Cycles   <= '0;
      Stall_Cycles <= '0;
    end else begin
      if (Busy && (Run_Cycles != '1)) begin
        Run_Cycles <= Run_Cycles + 32'd1;
      end
      if ((state == RUN) && Stall && (Stall_Cycles != '1)) begin
        Stall_Cycles <= Stall_Cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cgra_exec_ctrl.sv
// Self-checking bench for cgra_exec_ctrl: vector table, corner sequences, randomized runs vs. model.
module tb_cgra_exec_ctrl;

  localparam int AW    = 10;
  localparam int IW    = 16;
  localparam int DRAIN = 8;
  localparam int MAXC  = 80;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Start = 1'b0;
  logic          Abort = 1'b0;
  logic          Stall = 1'b0;
  logic [AW-1:0] Start_Addr = '0;
  logic [AW-1:0] End_Addr = '0;
  logic [IW-1:0] Iter_Num = '0;
  logic [AW-1:0] Inst_Addr;
  logic          CGRA_Ena;
  logic          Busy;
  logic          Done;
  logic          Err;
`ifdef CGRA_EXEC_PERF_CNT_EN
  logic [31:0]   Run_Cycles;
  logic [31:0]   Stall_Cycles;
`endif

  cgra_exec_ctrl #(
    .INST_AWIDTH  (AW),
    .ITER_WIDTH   (IW),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Start        (Start),
    .Abort        (Abort),
    .Stall        (Stall),
    .Start_Addr   (Start_Addr),
    .End_Addr     (End_Addr),
    .Iter_Num     (Iter_Num),
    .Inst_Addr    (Inst_Addr),
    .CGRA_Ena     (CGRA_Ena),
    .Busy         (Busy),
    .Done         (Done),
`ifdef CGRA_EXEC_PERF_CNT_EN
    .Err          (Err),
    .Run_Cycles   (Run_Cycles),
    .Stall_Cycles (Stall_Cycles)
`else
    .Err          (Err)
`endif
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  // Per-cycle stimulus and observations for one run; index = cycles after the Start cycle.
  bit            stall_vec [MAXC];
  logic          obs_ena   [MAXC];
  logic          obs_busy  [MAXC];
  logic          obs_done  [MAXC];
  logic          obs_err   [MAXC];
  logic [AW-1:0] obs_addr  [MAXC];

  bit exp_ena      [MAXC];
  bit exp_busy     [MAXC];
  bit exp_done     [MAXC];
  bit exp_err      [MAXC];
  bit exp_addr_vld [MAXC];
  int exp_addr     [MAXC];

  typedef struct {
    int s, e, n, st_from, st_len;
    int x_done, x_issue, x_busy, x_err, x_first, x_last, x_run, x_stall;
  } row_t;

  row_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_stall(input int from, input int len);
    for (int k = 0; k < MAXC; k++) stall_vec[k] = (k >= from) && (k < from + len);
  endtask

  // Issue-order model: build the address list, then replay cycles where a stall
  // turns the following cycle into a bubble and the last issue hands over to drain.
  task automatic model_run(input int s, input int e, input int n,
                           output int done_cyc, output int stall_run);
    int q[$];
    int k;
    int pos;
    bit issue;
    for (int i = 0; i < MAXC; i++) begin
      exp_ena[i] = 0; exp_busy[i] = 0; exp_done[i] = 0; exp_err[i] = 0;
      exp_addr_vld[i] = 0; exp_addr[i] = 0;
    end
    done_cyc = 0;
    stall_run = 0;
    if (e < s) begin
      exp_err[1] = 1;
      return;
    end
    if (n == 0) begin
      exp_busy[1] = 1;
      exp_done[2] = 1;
      done_cyc = 2;
      return;
    end
    for (int it = 0; it < n; it++)
      for (int a = s; a <= e; a++) q.push_back(a);
    k = 1;
    pos = 0;
    issue = 1;
    forever begin
      exp_busy[k] = 1;
      if (issue) begin
        exp_ena[k] = 1;
        pos++;
      end
      exp_addr[k] = q[pos-1];
      exp_addr_vld[k] = 1;
      if (stall_vec[k]) begin
        issue = 0;
        stall_run++;
      end else if (pos == q.size()) begin
        break;
      end else begin
        issue = 1;
      end
      k++;
    end
    for (int d = 1; d <= DRAIN; d++) begin
      exp_busy[k+d] = 1;
      exp_addr[k+d] = e;
      exp_addr_vld[k+d] = 1;
    end
    done_cyc = k + DRAIN + 1;
    exp_done[done_cyc] = 1;
    exp_addr[done_cyc] = e;
    exp_addr_vld[done_cyc] = 1;
  endtask

  task automatic run_one(input int s, input int e, input int n, input int ncyc);
    Start_Addr = AW'(s);
    End_Addr   = AW'(e);
    Iter_Num   = IW'(n);
    Stall      = 1'b0;
    Start      = 1'b1;
    tick();
    Start = 1'b0;
    for (int k = 1; k < ncyc; k++) begin
      obs_ena[k]  = CGRA_Ena;
      obs_busy[k] = Busy;
      obs_done[k] = Done;
      obs_err[k]  = Err;
      obs_addr[k] = Inst_Addr;
      Stall = stall_vec[k];
      tick();
    end
    Stall = 1'b0;
  endtask

  task automatic compare_model(input string tag, input int ncyc);
    for (int k = 1; k < ncyc; k++) begin
      check($sformatf("%s c%0d ena", tag, k), 32'(obs_ena[k]), 32'(exp_ena[k]));
      check($sformatf("%s c%0d busy", tag, k), 32'(obs_busy[k]), 32'(exp_busy[k]));
      check($sformatf("%s c%0d done", tag, k), 32'(obs_done[k]), 32'(exp_done[k]));
      check($sformatf("%s c%0d err", tag, k), 32'(obs_err[k]), 32'(exp_err[k]));
      if (exp_addr_vld[k])
        check($sformatf("%s c%0d addr", tag, k), 32'(obs_addr[k]), 32'(exp_addr[k]));
    end
  endtask

  initial begin
    int m_done, m_stall;
    int issue_cnt, busy_cnt, first_a, last_a, done_at, done_cnt, err_at, err_cnt;
    int s, e, n;

    // Rows: s, e, n, stall_from, stall_len | done, issues, busy, err, first, last, run, stall
    tbl[0] = '{0,    3,    2, 0, 0,  17, 8, 16, 0,  0,    3,    16, 0};
    tbl[1] = '{0,    3,    2, 3, 3,  20, 8, 19, 0,  0,    3,    19, 3};
    tbl[2] = '{5,    4,    2, 0, 0,  0,  0, 0,  1,  -1,   -1,   19, 3};
    tbl[3] = '{2,    6,    0, 0, 0,  2,  0, 1,  0,  -1,   -1,   1,  0};
    tbl[4] = '{7,    7,    3, 0, 0,  12, 3, 11, 0,  7,    7,    11, 0};
    tbl[5] = '{10,   12,   1, 3, 2,  14, 3, 13, 0,  10,   12,   13, 2};
    tbl[6] = '{1021, 1023, 2, 0, 0,  15, 6, 14, 0,  1021, 1023, 14, 0};

    tick();
    tick();
    check("rst addr", 32'(Inst_Addr), 32'd0);
    check("rst ena", 32'(CGRA_Ena), 32'd0);
    check("rst busy", 32'(Busy), 32'd0);
    check("rst done", 32'(Done), 32'd0);
    check("rst err", 32'(Err), 32'd0);
`ifdef CGRA_EXEC_PERF_CNT_EN
    check("rst run_cycles", Run_Cycles, 32'd0);
    check("rst stall_cycles", Stall_Cycles, 32'd0);
`endif
    Reset = 1'b0;
    tick();

    for (int r = 0; r < 7; r++) begin
      set_stall(tbl[r].st_from, tbl[r].st_len);
      run_one(tbl[r].s, tbl[r].e, tbl[r].n, 30);
      issue_cnt = 0; busy_cnt = 0; first_a = -1; last_a = -1;
      done_at = 0; done_cnt = 0; err_at = 0; err_cnt = 0;
      for (int k = 1; k < 30; k++) begin
        if (obs_ena[k] === 1'b1) begin
          issue_cnt++;
          if (first_a < 0) first_a = int'(obs_addr[k]);
          last_a = int'(obs_addr[k]);
        end
        if (obs_busy[k] === 1'b1) busy_cnt++;
        if (obs_done[k] === 1'b1) begin
          done_cnt++;
          if (done_at == 0) done_at = k;
        end
        if (obs_err[k] === 1'b1) begin
          err_cnt++;
          if (err_at == 0) err_at = k;
        end
      end
      check($sformatf("row%0d done cycle", r), done_at, tbl[r].x_done);
      check($sformatf("row%0d done pulses", r), done_cnt, (tbl[r].x_done != 0) ? 1 : 0);
      check($sformatf("row%0d issues", r), issue_cnt, tbl[r].x_issue);
      check($sformatf("row%0d busy cycles", r), busy_cnt, tbl[r].x_busy);
      check($sformatf("row%0d err cycle", r), err_at, tbl[r].x_err);
      check($sformatf("row%0d err pulses", r), err_cnt, (tbl[r].x_err != 0) ? 1 : 0);
      check($sformatf("row%0d first addr", r), first_a, tbl[r].x_first);
      check($sformatf("row%0d last addr", r), last_a, tbl[r].x_last);
`ifdef CGRA_EXEC_PERF_CNT_EN
      check($sformatf("row%0d run_cycles", r), Run_Cycles, tbl[r].x_run);
      check($sformatf("row%0d stall_cycles", r), Stall_Cycles, tbl[r].x_stall);
`endif
      model_run(tbl[r].s, tbl[r].e, tbl[r].n, m_done, m_stall);
      compare_model($sformatf("row%0d", r), 30);
    end

    // Start while busy, Abort racing Start, restart after Abort, Abort in IDLE.
    set_stall(0, 0);
    Start_Addr = 0; End_Addr = 3; Iter_Num = 2; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    Start_Addr = 9; End_Addr = 9; Start = 1'b1;
    tick();
    Start = 1'b0; Start_Addr = 0; End_Addr = 3;
    check("busy start ignored addr", 32'(Inst_Addr), 32'd2);
    check("busy start ignored ena", 32'(CGRA_Ena), 32'd1);
    tick();
    Abort = 1'b1; Start = 1'b1;
    tick();
    Abort = 1'b0; Start = 1'b0;
    check("abort busy", 32'(Busy), 32'd0);
    check("abort ena", 32'(CGRA_Ena), 32'd0);
    check("abort done", 32'(Done), 32'd0);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("restart busy", 32'(Busy), 32'd1);
    check("restart ena", 32'(CGRA_Ena), 32'd1);
    check("restart addr", 32'(Inst_Addr), 32'd0);
    Abort = 1'b1;
    tick();
    check("abort2 busy", 32'(Busy), 32'd0);
    tick();
    Abort = 1'b0;
    check("idle abort busy", 32'(Busy), 32'd0);
    check("idle abort err", 32'(Err), 32'd0);
    check("idle abort done", 32'(Done), 32'd0);

    // Start presented in the Done cycle is ignored.
    Start_Addr = 1; End_Addr = 1; Iter_Num = 1; Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("done cycle pulse", 32'(Done), 32'd1);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("done start ignored busy", 32'(Busy), 32'd0);
    tick();
    check("done start ignored busy2", 32'(Busy), 32'd0);
    check("done start ignored ena", 32'(CGRA_Ena), 32'd0);

    // Reset in the middle of DRAIN.
    Start_Addr = 5; End_Addr = 5; Iter_Num = 1; Start = 1'b1;
    tick();
    Start = 1'b0;
    check("pre-reset addr", 32'(Inst_Addr), 32'd5);
    tick(); tick(); tick();
    check("pre-reset busy", 32'(Busy), 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("mid reset addr", 32'(Inst_Addr), 32'd0);
    check("mid reset ena", 32'(CGRA_Ena), 32'd0);
    check("mid reset busy", 32'(Busy), 32'd0);
    check("mid reset done", 32'(Done), 32'd0);
    check("mid reset err", 32'(Err), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (Done !== 1'b0 || Busy !== 1'b0) done_cnt++;
      tick();
    end
    check("post reset quiet", done_cnt, 0);

    // Randomized windows, iteration counts and stall patterns against the model.
    for (int r = 0; r < 25; r++) begin
      s = $urandom_range(0, 20);
      e = s + $urandom_range(0, 4);
      n = $urandom_range(1, 3);
      if ($urandom_range(0, 7) == 0) n = 0;
      if ($urandom_range(0, 7) == 0) begin
        s = $urandom_range(1, 20);
        e = s - 1;
      end
      for (int k = 0; k < MAXC; k++) stall_vec[k] = (k > 0) && (k < 40) && ($urandom_range(0, 3) == 0);
      model_run(s, e, n, m_done, m_stall);
      run_one(s, e, n, 70);
      compare_model($sformatf("rnd%0d", r), 70);
`ifdef CGRA_EXEC_PERF_CNT_EN
      if (m_done != 0) begin
        check($sformatf("rnd%0d run_cycles", r), Run_Cycles, 32'(m_done - 1));
        check($sformatf("rnd%0d stall_cycles", r), Stall_Cycles, 32'(m_stall));
      end
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
